bit8_demux_buf: RTL and testbench

Registered 1-to-2 byte demultiplexer with per-output buffering; the inverse path of the 8-bit 2:1 select mux in the ALU/datapath library. Each accepted byte goes to output channel 0 or 1 according to `select`. It is held in that channel's small FIFO until the consumer takes it. One stalled consumer blocks only bytes addressed to it, never bytes already queued for the other channel.

---
 rtl/bit8_demux_buf_if.sv | 24 ++
 rtl/bit8_demux_buf.sv | 82 ++++++++
 tb/tb_bit8_demux_buf.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/bit8_demux_buf_if.sv
// rtl/bit8_demux_buf_if.sv - handshake bundle for the 1-to-2 byte demultiplexer
`timescale 1ns/1ps
interface bit8_demux_buf_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       select;
  logic       out0_valid;
  logic       out0_ready;
  logic [7:0] out0_data;
  logic       out1_valid;
  logic       out1_ready;
  logic [7:0] out1_data;

  modport slave (
    input  in_valid, in_data, select, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport master (
    output in_valid, in_data, select, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );
endinterface

// File: rtl/bit8_demux_buf.sv
// rtl/bit8_demux_buf.sv - registered 1-to-2 byte demux with a FIFO per output channel
// Optional per-channel pop counters are enabled by defining BIT8_DEMUX_CNT_EN.
`timescale 1ns/1ps
module bit8_demux_buf #(
  parameter int DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  bit8_demux_buf_if.slave   bus
`ifdef BIT8_DEMUX_CNT_EN
  ,
  output logic [15:0]       out0_count,
  output logic [15:0]       out1_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic in_ready_int;

  // in_ready only looks at registered occupancy, so consumer ready never reaches it.
  assign in_ready_int = bus.select ? !g_ch[1].full : !g_ch[0].full;
  assign bus.in_ready = in_ready_int;

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic          out_ready;
    logic          push;
    logic          pop;
    logic          full;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [7:0]    mem [DEPTH];

    assign out_ready = (ch == 0) ? bus.out0_ready : bus.out1_ready;
    assign full      = (count == CW'(DEPTH));
    assign push      = bus.in_valid && in_ready_int && (bus.select == 1'(ch));
    assign pop       = (count != '0) && out_ready;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= bus.in_data;
    end

`ifdef BIT8_DEMUX_CNT_EN
    logic [15:0] pop_count;

    always_ff @(posedge clock or posedge reset) begin
      if (reset)    pop_count <= '0;
      else if (pop) pop_count <= pop_count + 16'd1;
    end
`endif
  end

  assign bus.out0_valid = (g_ch[0].count != '0);
  assign bus.out1_valid = (g_ch[1].count != '0);
  assign bus.out0_data  = g_ch[0].mem[g_ch[0].rd_ptr];
  assign bus.out1_data  = g_ch[1].mem[g_ch[1].rd_ptr];

`ifdef BIT8_DEMUX_CNT_EN
  assign out0_count = g_ch[0].pop_count;
  assign out1_count = g_ch[1].pop_count;
`endif

endmodule

// File: tb/tb_bit8_demux_buf.sv
// tb/tb_bit8_demux_buf.sv - scoreboard bench for bit8_demux_buf against a queue model
`timescale 1ns/1ps
module tb_bit8_demux_buf;
  localparam int DEPTH = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  bit8_demux_buf_if bif ();

`ifdef BIT8_DEMUX_CNT_EN
  logic [15:0] out0_count;
  logic [15:0] out1_count;
  logic [15:0] cnt0 = '0;
  logic [15:0] cnt1 = '0;
`endif

  bit8_demux_buf #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
`ifdef BIT8_DEMUX_CNT_EN
    ,
    .out0_count (out0_count),
    .out1_count (out1_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the model FIFO content decides what in_ready must be.
  task automatic drive(input logic v, input logic s, input logic [7:0] d,
                       input logic r0, input logic r1, output logic acc);
    logic exp_rdy;
    @(negedge clock);
    bif.in_valid   = v;
    bif.select     = s;
    bif.in_data    = d;
    bif.out0_ready = r0;
    bif.out1_ready = r1;
    #1;
    exp_rdy = s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    chk("in_ready", int'(bif.in_ready), int'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clock);
    if (acc) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
  endtask

  task automatic push_wait(input logic s, input logic [7:0] d, input logic r0,
                           input logic r1, input int max_cycles);
    logic acc = 1'b0;
    for (int i = 0; i < max_cycles && !acc; i++) drive(1'b1, s, d, r0, r1, acc);
    chk("push_timeout", int'(acc), 1);
  endtask

  task automatic idle(input logic r0, input logic r1, input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, r0, r1, acc);
  endtask

  task automatic async_reset();
    @(negedge clock);
    bif.in_valid   = 1'b0;
    bif.out0_ready = 1'b0;
    bif.out1_ready = 1'b0;
    #2;
    reset = 1'b1;
    q0.delete();
    q1.delete();
`ifdef BIT8_DEMUX_CNT_EN
    cnt0 = '0;
    cnt1 = '0;
`endif
    #0.5;
    chk("rst_out0_valid", int'(bif.out0_valid), 0);
    chk("rst_out1_valid", int'(bif.out1_valid), 0);
    chk("rst_in_ready", int'(bif.in_ready), 1);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Monitor: compares DUT outputs with the model heads and retires popped bytes.
  initial begin
    forever begin
      @(negedge clock);
      #3;
      if (!reset) begin
        chk("out0_valid", int'(bif.out0_valid), int'(q0.size() != 0));
        chk("out1_valid", int'(bif.out1_valid), int'(q1.size() != 0));
`ifdef BIT8_DEMUX_CNT_EN
        chk("out0_count", int'(out0_count), int'(cnt0));
        chk("out1_count", int'(out1_count), int'(cnt1));
`endif
        if (q0.size() != 0) begin
          chk("out0_data", int'(bif.out0_data), int'(q0[0]));
          if (bif.out0_ready) begin
            void'(q0.pop_front());
`ifdef BIT8_DEMUX_CNT_EN
            cnt0 = cnt0 + 16'd1;
`endif
          end
        end
        if (q1.size() != 0) begin
          chk("out1_data", int'(bif.out1_data), int'(q1[0]));
          if (bif.out1_ready) begin
            void'(q1.pop_front());
`ifdef BIT8_DEMUX_CNT_EN
            cnt1 = cnt1 + 16'd1;
`endif
          end
        end
      end
    end
  end

  initial begin
    logic acc;
    bif.in_valid   = 1'b0;
    bif.select     = 1'b0;
    bif.in_data    = 8'h00;
    bif.out0_ready = 1'b0;
    bif.out1_ready = 1'b0;
    #1;
    chk("reset_in_ready", int'(bif.in_ready), 1);
    chk("reset_out0_valid", int'(bif.out0_valid), 0);
    chk("reset_out1_valid", int'(bif.out1_valid), 0);
    @(negedge clock);
    reset = 1'b0;

    // Reset then route
    push_wait(1'b0, 8'hA5, 1'b1, 1'b1, 2);
    push_wait(1'b1, 8'h3C, 1'b1, 1'b1, 2);
    idle(1'b1, 1'b1, 3);

    // Full/backpressure on channel 0, with isolation on channel 1
    push_wait(1'b0, 8'h01, 1'b0, 1'b0, 2);
    push_wait(1'b0, 8'h02, 1'b0, 1'b0, 2);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h03, 1'b0, 1'b0, acc);
    push_wait(1'b1, 8'h77, 1'b0, 1'b0, 1);
    idle(1'b0, 1'b1, 2);
    push_wait(1'b0, 8'h03, 1'b1, 1'b0, 3);
    idle(1'b1, 1'b1, 4);

    // Simultaneous push and pop on channel 1 holding one entry
    push_wait(1'b1, 8'h0F, 1'b0, 1'b0, 2);
    for (int i = 0; i < 8; i++) push_wait(1'b1, 8'h10 + 8'(i), 1'b0, 1'b1, 1);
    idle(1'b1, 1'b1, 3);

    // Mid-operation reset with both channels holding two entries
    push_wait(1'b0, 8'hC1, 1'b0, 1'b0, 2);
    push_wait(1'b0, 8'hC2, 1'b0, 1'b0, 2);
    push_wait(1'b1, 8'hD1, 1'b0, 1'b0, 2);
    push_wait(1'b1, 8'hD2, 1'b0, 1'b0, 2);
    async_reset();
    idle(1'b1, 1'b1, 3);
    push_wait(1'b1, 8'hE7, 1'b1, 1'b1, 2);
    idle(1'b1, 1'b1, 2);

    // Randomised traffic with independent consumer stalls
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 8'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, acc);
    end
    idle(1'b1, 1'b1, 2 * DEPTH + 2);

`ifdef BIT8_DEMUX_CNT_EN
    for (int i = 0; i < 65540; i++) drive(1'b1, 1'b0, 8'(i), 1'b1, 1'b0, acc);
    idle(1'b1, 1'b1, 3);
`endif

    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
